// File: rtl/input_ctrl.sv
// rtl/input_ctrl.sv - button debounce, press/long-press pulses and confirm-latched switch capture
// Raw inputs pass a 2-FF synchronizer; buttons are then debounced per bit, switches are not.
module input_ctrl #(
  parameter int NUM_BTN           = 5,
  parameter int SW_WIDTH          = 8,
  parameter int DEBOUNCE_CYCLES   = 20,
  parameter int LONG_PRESS_CYCLES = 50
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_BTN-1:0]  btn_raw,
  input  logic [SW_WIDTH-1:0] sw_raw,
  output logic [NUM_BTN-1:0]  btn_level,
  output logic [NUM_BTN-1:0]  btn_pulse,
  output logic [NUM_BTN-1:0]  btn_long,
  output logic [SW_WIDTH-1:0] sw_sync,
  output logic                data_valid,
  output logic [SW_WIDTH-1:0] data_value,
  input  logic                data_ready,
  output logic                overrun
);

  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [CNT_W-1:0]  DB_LAST  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_PRESS_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(LONG_PRESS_CYCLES - 1);

  logic [NUM_BTN-1:0]  btn_s1;
  logic [NUM_BTN-1:0]  btn_s2;
  logic [SW_WIDTH-1:0] sw_s1;
  logic [SW_WIDTH-1:0] sw_s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_s1 <= '0;
      btn_s2 <= '0;
      sw_s1  <= '0;
      sw_s2  <= '0;
    end else begin
      btn_s1 <= btn_raw;
      btn_s2 <= btn_s1;
      sw_s1  <= sw_raw;
      sw_s2  <= sw_s1;
    end
  end

  assign sw_sync = sw_s2;

  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
    logic              db_counting;
    logic [CNT_W-1:0]  db_cnt;
    logic [CNT_W-1:0]  db_cnt_next;
    logic              db_differ;
    logic              db_accept;
    logic              level_q;
    logic              pulse_q;
    logic              long_q;
    logic [HOLD_W-1:0] hold_q;

    // The first differing cycle counts as 1, so acceptance lands DEBOUNCE_CYCLES edges later.
    always_comb begin
      db_differ   = btn_s2[gi] ^ level_q;
      db_cnt_next = db_counting ? db_cnt + 1'b1 : CNT_W'(1);
      db_accept   = db_differ && (db_cnt_next >= DB_LAST);
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        db_counting <= 1'b0;
        db_cnt      <= '0;
        level_q     <= 1'b0;
        pulse_q     <= 1'b0;
      end else begin
        pulse_q <= db_accept & btn_s2[gi];
        if (!db_differ || db_accept) begin
          db_counting <= 1'b0;
          db_cnt      <= '0;
        end else begin
          db_counting <= 1'b1;
          db_cnt      <= db_cnt_next;
        end
        if (db_accept) begin
          level_q <= btn_s2[gi];
        end
      end
    end

    // Hold counter saturates, so a continued hold never fires a second long pulse.
    always_ff @(posedge clk) begin
      if (rst) begin
        hold_q <= '0;
        long_q <= 1'b0;
      end else if (level_q) begin
        if (hold_q != HOLD_MAX) begin
          hold_q <= hold_q + 1'b1;
        end
        long_q <= (hold_q == HOLD_PRE);
      end else begin
        hold_q <= '0;
        long_q <= 1'b0;
      end
    end

    assign btn_level[gi] = level_q;
    assign btn_pulse[gi] = pulse_q;
    assign btn_long[gi]  = long_q;
  end

  typedef enum logic {
    CAP_EMPTY = 1'b0,
    CAP_FULL  = 1'b1
  } cap_state_t;

  cap_state_t cap_state;
  cap_state_t cap_state_next;
  logic       confirm;
  logic       cap_load;
  logic       cap_drop;
  logic       cap_clear_ovr;

  assign confirm = btn_pulse[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_state <= CAP_EMPTY;
    end else begin
      cap_state <= cap_state_next;
    end
  end

  always_comb begin
    cap_state_next = cap_state;
    case (cap_state)
      CAP_EMPTY: if (confirm) cap_state_next = CAP_FULL;
      CAP_FULL:  if (data_ready && !confirm) cap_state_next = CAP_EMPTY;
      default:   cap_state_next = CAP_EMPTY;
    endcase
  end

  // A confirm coinciding with an accept replaces the word rather than being dropped.
  always_comb begin
    data_valid    = (cap_state == CAP_FULL);
    cap_load      = confirm && ((cap_state == CAP_EMPTY) || data_ready);
    cap_drop      = confirm && (cap_state == CAP_FULL) && !data_ready;
    cap_clear_ovr = (cap_state == CAP_FULL) && data_ready && !confirm;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_value <= '0;
      overrun    <= 1'b0;
    end else begin
      if (cap_load) begin
        data_value <= sw_s2;
      end
      if (cap_drop) begin
        overrun <= 1'b1;
      end else if (cap_clear_ovr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_input_ctrl.sv
// tb/tb_input_ctrl.sv - directed vector and sequence bench for input_ctrl
module tb_input_ctrl;
  localparam int NB = 5;
  localparam int SW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NB-1:0] btn_raw = '0;
  logic [SW-1:0] sw_raw = '0;
  logic          data_ready = 1'b0;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_pulse;
  logic [NB-1:0] btn_long;
  logic [SW-1:0] sw_sync;
  logic          data_valid;
  logic [SW-1:0] data_value;
  logic          overrun;

  always #5 clk = ~clk;

  input_ctrl #(
    .NUM_BTN(NB), .SW_WIDTH(SW), .DEBOUNCE_CYCLES(20), .LONG_PRESS_CYCLES(50)
  ) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .sw_raw(sw_raw),
    .btn_level(btn_level), .btn_pulse(btn_pulse), .btn_long(btn_long),
    .sw_sync(sw_sync), .data_valid(data_valid), .data_value(data_value),
    .data_ready(data_ready), .overrun(overrun)
  );

  int tests = 0;
  int fails = 0;
  int ncyc = 0;
  int pulse_cnt [NB] = '{default: 0};
  int long_cnt  [NB] = '{default: 0};
  int pulse_at  [NB] = '{default: 0};
  int long_at   [NB] = '{default: 0};
  int rise_at   [NB] = '{default: 0};
  logic [NB-1:0] prev_level = '0;

  always @(negedge clk) begin
    ncyc++;
    for (int i = 0; i < NB; i++) begin
      if (btn_pulse[i] === 1'b1) begin
        pulse_cnt[i]++;
        pulse_at[i] = ncyc;
      end
      if (btn_long[i] === 1'b1) begin
        long_cnt[i]++;
        long_at[i] = ncyc;
      end
      if (btn_level[i] === 1'b1 && prev_level[i] !== 1'b1) rise_at[i] = ncyc;
    end
    prev_level = btn_level;
  end

  typedef struct {
    logic [NB-1:0] btn;
    logic [SW-1:0] sw;
    logic          rdy;
    int            n;
    logic [NB-1:0] exp_level;
    logic [SW-1:0] exp_sw;
    logic          exp_valid;
    logic          chk_value;
    logic [SW-1:0] exp_value;
    logic          exp_ovr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [NB-1:0] btn, input logic [SW-1:0] sw, input logic rdy,
                     input int n, input logic [NB-1:0] lvl, input logic [SW-1:0] esw,
                     input logic vld, input logic cv, input logic [SW-1:0] val, input logic ovr);
    vec_t v;
    v = '{btn, sw, rdy, n, lvl, esw, vld, cv, val, ovr};
    vecs.push_back(v);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  int base_p;
  int base_l;

  initial begin
    // btn, sw, rdy, ticks | level, sw_sync, valid, check_value, value, overrun
    add(5'h00, 8'hA5, 1'b0,  3, 5'h00, 8'hA5, 1'b0, 1'b1, 8'h00, 1'b0);
    add(5'h01, 8'hA5, 1'b0, 21, 5'h00, 8'hA5, 1'b0, 1'b1, 8'h00, 1'b0);
    add(5'h01, 8'hA5, 1'b0,  1, 5'h01, 8'hA5, 1'b0, 1'b1, 8'h00, 1'b0);
    add(5'h01, 8'hA5, 1'b0,  1, 5'h01, 8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0);
    add(5'h00, 8'hA5, 1'b0, 10, 5'h01, 8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0);
    add(5'h00, 8'hA5, 1'b1,  1, 5'h01, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b0);
    add(5'h00, 8'hA5, 1'b0, 20, 5'h00, 8'hA5, 1'b0, 1'b0, 8'h00, 1'b0);
    add(5'h01, 8'hA5, 1'b0, 23, 5'h01, 8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0);
    add(5'h00, 8'h3C, 1'b0, 25, 5'h00, 8'h3C, 1'b1, 1'b1, 8'hA5, 1'b0);
    add(5'h01, 8'h3C, 1'b0, 23, 5'h01, 8'h3C, 1'b1, 1'b1, 8'hA5, 1'b1);
    add(5'h01, 8'h3C, 1'b1,  1, 5'h01, 8'h3C, 1'b0, 1'b0, 8'h00, 1'b0);
    add(5'h00, 8'h3C, 1'b0, 25, 5'h00, 8'h3C, 1'b0, 1'b0, 8'h00, 1'b0);
    add(5'h01, 8'h3C, 1'b0, 23, 5'h01, 8'h3C, 1'b1, 1'b1, 8'h3C, 1'b0);
    add(5'h00, 8'h5A, 1'b0, 25, 5'h00, 8'h5A, 1'b1, 1'b1, 8'h3C, 1'b0);
    add(5'h01, 8'h5A, 1'b0, 22, 5'h01, 8'h5A, 1'b1, 1'b1, 8'h3C, 1'b0);
    add(5'h01, 8'h5A, 1'b1,  1, 5'h01, 8'h5A, 1'b1, 1'b1, 8'h5A, 1'b0);
    add(5'h01, 8'h5A, 1'b0,  1, 5'h01, 8'h5A, 1'b1, 1'b1, 8'h5A, 1'b0);
    add(5'h00, 8'h5A, 1'b1,  1, 5'h01, 8'h5A, 1'b0, 1'b0, 8'h00, 1'b0);
    add(5'h00, 8'h5A, 1'b0, 25, 5'h00, 8'h5A, 1'b0, 1'b0, 8'h00, 1'b0);
    add(5'h00, 8'h5A, 1'b1,  3, 5'h00, 8'h5A, 1'b0, 1'b0, 8'h00, 1'b0);

    rst = 1'b1;
    tick(3);
    chk("reset btn_level", 32'(btn_level), 32'h0);
    chk("reset btn_pulse", 32'(btn_pulse), 32'h0);
    chk("reset btn_long", 32'(btn_long), 32'h0);
    chk("reset sw_sync", 32'(sw_sync), 32'h0);
    chk("reset data_valid", 32'(data_valid), 32'h0);
    chk("reset data_value", 32'(data_value), 32'h0);
    chk("reset overrun", 32'(overrun), 32'h0);
    rst = 1'b0;

    foreach (vecs[k]) begin
      btn_raw    = vecs[k].btn;
      sw_raw     = vecs[k].sw;
      data_ready = vecs[k].rdy;
      tick(vecs[k].n);
      chk($sformatf("vec%0d btn_level", k), 32'(btn_level), 32'(vecs[k].exp_level));
      chk($sformatf("vec%0d sw_sync", k), 32'(sw_sync), 32'(vecs[k].exp_sw));
      chk($sformatf("vec%0d data_valid", k), 32'(data_valid), 32'(vecs[k].exp_valid));
      chk($sformatf("vec%0d overrun", k), 32'(overrun), 32'(vecs[k].exp_ovr));
      if (vecs[k].chk_value) begin
        chk($sformatf("vec%0d data_value", k), 32'(data_value), 32'(vecs[k].exp_value));
      end
    end
    data_ready = 1'b0;

    // Clean press on btn 2: level visible 22 samples after the drive, pulse one cycle wide.
    base_p = pulse_cnt[2];
    btn_raw = 5'h04;
    tick(21);
    chk("btn2 level before latency", 32'(btn_level), 32'h0);
    tick(1);
    chk("btn2 level at latency", 32'(btn_level), 32'h04);
    chk("btn2 pulse at latency", 32'(btn_pulse), 32'h04);
    tick(1);
    chk("btn2 pulse after one cycle", 32'(btn_pulse), 32'h0);
    chk("btn2 level held", 32'(btn_level), 32'h04);
    btn_raw = 5'h00;
    tick(25);
    chk("btn2 level released", 32'(btn_level), 32'h0);
    chk("btn2 pulse count", 32'(pulse_cnt[2] - base_p), 32'd1);
    chk("btn2 no capture", 32'(data_valid), 32'h0);

    // 19-cycle glitch on btn 1 is rejected; a 20-cycle hold is accepted.
    base_p = pulse_cnt[1];
    btn_raw = 5'h02;
    tick(19);
    btn_raw = 5'h00;
    tick(30);
    chk("btn1 glitch level", 32'(btn_level), 32'h0);
    chk("btn1 glitch pulses", 32'(pulse_cnt[1] - base_p), 32'd0);
    btn_raw = 5'h02;
    tick(20);
    btn_raw = 5'h00;
    tick(2);
    chk("btn1 20-cycle level", 32'(btn_level), 32'h02);
    tick(30);
    chk("btn1 20-cycle released", 32'(btn_level), 32'h0);
    chk("btn1 20-cycle pulses", 32'(pulse_cnt[1] - base_p), 32'd1);

    // Long press on btn 3, repeated after a release.
    for (int r = 0; r < 2; r++) begin
      base_p = pulse_cnt[3];
      base_l = long_cnt[3];
      btn_raw = 5'h08;
      tick(100);
      chk($sformatf("long%0d pulse count", r), 32'(pulse_cnt[3] - base_p), 32'd1);
      chk($sformatf("long%0d long count", r), 32'(long_cnt[3] - base_l), 32'd1);
      chk($sformatf("long%0d pulse with rise", r), 32'(pulse_at[3] - rise_at[3]), 32'd0);
      chk($sformatf("long%0d long delay", r), 32'(long_at[3] - rise_at[3]), 32'd50);
      btn_raw = 5'h00;
      tick(30);
      chk($sformatf("long%0d released", r), 32'(btn_level), 32'h0);
      chk($sformatf("long%0d no extra long", r), 32'(long_cnt[3] - base_l), 32'd1);
    end

    // Reset while FULL with overrun set and btn 0 mid-debounce.
    sw_raw  = 8'h77;
    btn_raw = 5'h01;
    tick(23);
    chk("rstseq capture valid", 32'(data_valid), 32'h1);
    chk("rstseq capture value", 32'(data_value), 32'h77);
    btn_raw = 5'h00;
    sw_raw  = 8'h11;
    tick(25);
    btn_raw = 5'h01;
    tick(23);
    chk("rstseq overrun set", 32'(overrun), 32'h1);
    chk("rstseq value kept", 32'(data_value), 32'h77);
    btn_raw = 5'h00;
    tick(25);
    btn_raw = 5'h01;
    tick(10);
    rst = 1'b1;
    tick(1);
    chk("rstseq btn_level", 32'(btn_level), 32'h0);
    chk("rstseq btn_pulse", 32'(btn_pulse), 32'h0);
    chk("rstseq btn_long", 32'(btn_long), 32'h0);
    chk("rstseq sw_sync", 32'(sw_sync), 32'h0);
    chk("rstseq data_valid", 32'(data_valid), 32'h0);
    chk("rstseq data_value", 32'(data_value), 32'h0);
    chk("rstseq overrun", 32'(overrun), 32'h0);
    base_p = pulse_cnt[0];
    rst = 1'b0;
    tick(25);
    chk("rstseq redebounce level", 32'(btn_level), 32'h01);
    chk("rstseq redebounce pulses", 32'(pulse_cnt[0] - base_p), 32'd1);
    chk("rstseq new capture valid", 32'(data_valid), 32'h1);
    chk("rstseq new capture value", 32'(data_value), 32'h11);
    chk("rstseq overrun after", 32'(overrun), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
